iterative_shifter: RTL and testbench

Multi-cycle, parametrised shift unit for the execute stage. It performs SLL, SRL and SRA on an XLEN-bit operand, processing up to STEP bit positions per clock. A start/done handshake lets the pipeline stall on it, so the datapath has no full-width barrel shifter. It replaces the single-cycle arithmetic-right-only shifter, adds left and logical-right modes, and supports a pipeline kill.

---
 rtl/iterative_shifter.sv | 95 +++++++++
 tb/tb_iterative_shifter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: shifts up to STEP bit positions per clock
// behind a start/done handshake, with a synchronous kill for pipeline flushes.
module iterative_shifter #(
  parameter  int XLEN = 32,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand,
  input  logic [SHW-1:0]  shamt,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW:0]    STEP_W = (SHW+1)'(STEP);
  localparam logic [XLEN-1:0] ONES   = '1;

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [SHW:0]    rem;
  logic [1:0]      mode;
  logic            sign;

  logic [SHW:0]    k;
  logic [SHW:0]    rem_nxt;
  logic [XLEN-1:0] fill;
  logic [XLEN-1:0] acc_nxt;

  // One partial shift of at most STEP positions; only SRA fills from the captured sign.
  always_comb begin
    k       = (rem > STEP_W) ? STEP_W : rem;
    rem_nxt = rem - k;
    fill    = (mode == 2'b11 && sign) ? ~(ONES >> k) : '0;
    if (mode[0]) acc_nxt = (acc >> k) | fill;
    else         acc_nxt = acc << k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      mode   <= '0;
      sign   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_nxt;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back issue.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            acc  <= operand;
            rem  <= {1'b0, shamt};
            mode <= op;
            sign <= operand[XLEN-1];
            if (shamt == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= operand;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: two instances (STEP=1 and STEP=4)
// checked against an arithmetic shift model with latency and busy-length expectations.
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  int          sel;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;

  logic        busy_o [2];
  logic        done_o [2];
  logic [31:0] res_o  [2];

  typedef struct {
    logic [31:0] res;
    int          due;
    int          nbusy;
  } exp_t;

  exp_t        sb [2][$];
  logic [31:0] model_res [2];
  logic [31:0] mon_last [2];
  int          bcnt [2];
  int          cyc;
  int          checks;
  int          passes;

  iterative_shifter #(.XLEN(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .op(op), .operand(operand),
    .shamt(shamt), .kill(kill && sel == 0), .busy(busy_o[0]), .done(done_o[0]), .result(res_o[0])
  );

  iterative_shifter #(.XLEN(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .op(op), .operand(operand),
    .shamt(shamt), .kill(kill && sel == 1), .busy(busy_o[1]), .done(done_o[1]), .result(res_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
    if (!o[0])     return a << s;
    else if (o[1]) return $signed(a) >>> s;
    else           return a >> s;
  endfunction

  // Called at a negedge; returns at the following negedge with start dropped.
  task automatic start_op(input int d, input logic [1:0] o, input logic [31:0] a, input int s);
    exp_t e;
    int   st = (d == 0) ? 1 : 4;
    sel = d; op = o; operand = a; shamt = 5'(s); start = 1'b1;
    e.res   = ref_shift(o, a, s);
    e.nbusy = (s + st - 1) / st;
    e.due   = cyc + 1 + e.nbusy;
    sb[d].push_back(e);
    model_res[d] = e.res;
    @(negedge clk);
    start = 1'b0; operand = $urandom; shamt = 5'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 200; i++) begin
      if (done_o[d]) break;
      @(negedge clk);
    end
    chk(done_o[d], "done timeout", 64'(done_o[d]), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops an expectation on every done pulse, otherwise checks that result holds.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        bcnt[d]     = 0;
        mon_last[d] = '0;
      end else if (done_o[d]) begin
        if (sb[d].size() == 0) begin
          chk(1'b0, "unexpected done", res_o[d], 0);
        end else begin
          e = sb[d].pop_front();
          chk(res_o[d] == e.res, "result", res_o[d], e.res);
          chk(cyc == e.due, "done latency", 64'(cyc), 64'(e.due));
          chk(bcnt[d] == e.nbusy, "busy cycles", 64'(bcnt[d]), 64'(e.nbusy));
          chk(!busy_o[d], "busy during done", 64'(busy_o[d]), 0);
          mon_last[d] = e.res;
        end
        bcnt[d] = 0;
      end else begin
        chk(res_o[d] == mon_last[d], "result hold", res_o[d], mon_last[d]);
        if (busy_o[d]) bcnt[d]++;
        else           bcnt[d] = 0;
      end
    end
  end

  initial begin
    int d;
    checks = 0; passes = 0;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; sel = 0;
    op = '0; operand = '0; shamt = '0;
    model_res[0] = '0; model_res[1] = '0;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      chk(busy_o[i] == 1'b0, "reset busy", 64'(busy_o[i]), 0);
      chk(done_o[i] == 1'b0, "reset done", 64'(done_o[i]), 0);
      chk(res_o[i] == '0, "reset result", res_o[i], 0);
    end
    rst_n = 1'b1;
    idle(2);

    // STEP=1 directed cases
    start_op(0, 2'b11, 32'h8000_0000, 31); wait_done(0); idle(2);
    start_op(0, 2'b01, 32'h8000_0000, 4);  wait_done(0); idle(1);
    start_op(0, 2'b00, 32'h0000_0001, 31); wait_done(0); idle(1);
    start_op(0, 2'b10, 32'h0000_0003, 1);  wait_done(0); idle(1);
    start_op(0, 2'b11, 32'hDEAD_BEEF, 0);  wait_done(0); idle(2);

    // back-to-back, plus a start during busy that must be ignored
    start_op(0, 2'b00, 32'h0000_0001, 2);  wait_done(0);
    start_op(0, 2'b01, 32'h0000_0100, 4);
    sel = 0; op = 2'b00; operand = 32'h1234_5678; shamt = 5'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(0); idle(2);

    // kill on the third SHIFT cycle
    sel = 0; op = 2'b11; operand = 32'h8000_0000; shamt = 5'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(2);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk(busy_o[0] == 1'b0, "kill busy", 64'(busy_o[0]), 0);
    chk(done_o[0] == 1'b0, "kill done", 64'(done_o[0]), 0);
    chk(res_o[0] == model_res[0], "kill result", res_o[0], model_res[0]);
    idle(12);

    // kill while idle drops a simultaneous start
    sel = 0; op = 2'b00; operand = 32'hFFFF_0000; shamt = 5'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    idle(4);

    // STEP=4 directed case
    start_op(1, 2'b11, 32'hF000_0000, 13); wait_done(1); idle(2);

    // randomized mix on both instances
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(1, 0));
      start_op(d, 2'($urandom), $urandom, int'($urandom_range(31, 0)));
      wait_done(d);
      if ($urandom_range(1, 0) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(3);

    // asynchronous reset in the middle of a shift
    start_op(1, 2'b11, 32'h8000_0000, 20);
    idle(2);
    #2 rst_n = 1'b0;
    sb[1].delete();
    model_res[0] = '0; model_res[1] = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(busy_o[i] == 1'b0, "async reset busy", 64'(busy_o[i]), 0);
      chk(done_o[i] == 1'b0, "async reset done", 64'(done_o[i]), 0);
      chk(res_o[i] == '0, "async reset result", res_o[i], 0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    start_op(1, 2'b01, 32'hCAFE_F00D, 9); wait_done(1);
    idle(5);

    chk(sb[0].size() == 0 && sb[1].size() == 0, "scoreboard drained",
        64'(sb[0].size() + sb[1].size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
